// File: rtl/tcore_mem_arbiter.sv
// tcore_mem_arbiter: shares the single main-memory port between the icache miss path (ilowX)
// and the dcache miss/writeback/uncached path (dlowX). One transaction outstanding at a time:
// grant, latch the winner's request, drive it to memory, wait for the response, route it back.
//
// Ports:
//   clk_i            clock
//   rst_i            asynchronous, active-high reset
//   ireq_i / ires_o  icache request / response (ready = one-cycle accept pulse, blk = read block)
//   dreq_i / dres_o  dcache request / response (ready = one-cycle accept pulse, data = read block)
//   mem_req_o        memory request (valid, block-aligned addr, data, rw = byte write mask)
//   mem_ready_i      memory accepted mem_req_o this cycle
//   mem_res_valid_i  memory response/ack valid
//   mem_res_data_i   memory read data

package tcore_mem_arbiter_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BLK_SIZE  = 128;
    localparam int unsigned BLK_BYTES = BLK_SIZE / 8;

    typedef enum logic [1:0] {
        NO_SIZE   = 2'd0,
        BYTE      = 2'd1,
        HALF_WORD = 2'd2,
        WORD      = 2'd3
    } rw_size_t;

    typedef struct packed {
        logic            valid;
        logic            ready;
        logic [XLEN-1:0] addr;
        logic            uncached;
    } ilowX_req_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [BLK_SIZE-1:0] blk;
    } ilowX_res_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [XLEN-1:0]     addr;
        rw_size_t            rw_size;
        logic                rw;
        logic [BLK_SIZE-1:0] data;
        logic                uncached;
    } dlowX_req_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [BLK_SIZE-1:0] data;
    } dlowX_res_t;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      addr;
        logic [BLK_SIZE-1:0]  data;
        logic [BLK_BYTES-1:0] rw;
    } mem_req_t;

endpackage

module tcore_mem_arbiter
    import tcore_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = XLEN,
    parameter int unsigned BLK_W  = BLK_SIZE,
    parameter int unsigned D_PRIO = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  ilowX_req_t       ireq_i,
    output ilowX_res_t       ires_o,
    input  dlowX_req_t       dreq_i,
    output dlowX_res_t       dres_o,
    output mem_req_t         mem_req_o,
    input  logic             mem_ready_i,
    input  logic             mem_res_valid_i,
    input  logic [BLK_W-1:0] mem_res_data_i
);

    localparam int unsigned MASK_W = BLK_W / 8;

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    state_e             state_q, state_d;
    logic               last_d_q, last_d_d;   // 1: most recent grant went to the dcache
    logic               gnt_d_q, gnt_d_d;     // owner of the outstanding transaction
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [BLK_W-1:0]   req_data_q, req_data_d;
    logic [MASK_W-1:0]  req_mask_q, req_mask_d;
    logic               ires_valid_q, ires_valid_d;
    logic               dres_valid_q, dres_valid_d;
    logic [BLK_W-1:0]   res_data_q, res_data_d;
    logic               grant, pick_d, capture;
    logic [MASK_W-1:0]  size_mask, unc_mask;

    // Fields the arbiter never looks at.
    logic unused_fields;
    assign unused_fields = ^{ireq_i.ready, ireq_i.uncached, ireq_i.addr[3:0], dreq_i.ready};

    // Uncached store: byte run for the access size, moved to the block offset. Bytes that would
    // land past the end of the block simply drop off (misalignment is flagged upstream).
    always_comb begin
        case (dreq_i.rw_size)
            BYTE:      size_mask = MASK_W'(4'h1);
            HALF_WORD: size_mask = MASK_W'(4'h3);
            WORD:      size_mask = MASK_W'(4'hF);
            default:   size_mask = '0;
        endcase
        unc_mask = size_mask << dreq_i.addr[3:0];
    end

    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        gnt_d_d      = gnt_d_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        req_mask_d   = req_mask_q;
        res_data_d   = res_data_q;
        ires_valid_d = 1'b0;
        dres_valid_d = 1'b0;
        grant        = 1'b0;
        pick_d       = 1'b0;
        capture      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ireq_i.valid || dreq_i.valid) begin
                    grant = 1'b1;
                    if (ireq_i.valid && dreq_i.valid) begin
                        pick_d = (D_PRIO != 0) ? 1'b1 : !last_d_q;
                    end else begin
                        pick_d = dreq_i.valid;
                    end
                    last_d_d = pick_d;
                    gnt_d_d  = pick_d;
                    state_d  = StSend;
                    req_mask_d = '0;
                    req_data_d = '0;
                    if (pick_d) begin
                        req_addr_d = {dreq_i.addr[ADDR_W-1:4], 4'b0};
                        if (dreq_i.rw && !dreq_i.uncached) begin
                            req_mask_d = '1;
                            req_data_d = dreq_i.data;
                        end else if (dreq_i.rw) begin
                            req_mask_d = unc_mask;
                            req_data_d = {(BLK_W / 32){dreq_i.data[31:0]}};
                        end
                    end else begin
                        req_addr_d = {ireq_i.addr[ADDR_W-1:4], 4'b0};
                    end
                end
            end
            StSend: begin
                if (mem_ready_i) begin
                    // A response in the accepting cycle completes the transaction immediately.
                    capture = mem_res_valid_i;
                    state_d = mem_res_valid_i ? StIdle : StWait;
                end
            end
            StWait: begin
                if (mem_res_valid_i) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            res_data_d   = mem_res_data_i;
            ires_valid_d = !gnt_d_q;
            dres_valid_d = gnt_d_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_d_q     <= 1'b0;
            gnt_d_q      <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_mask_q   <= '0;
            res_data_q   <= '0;
            ires_valid_q <= 1'b0;
            dres_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_d_q     <= last_d_d;
            gnt_d_q      <= gnt_d_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_mask_q   <= req_mask_d;
            res_data_q   <= res_data_d;
            ires_valid_q <= ires_valid_d;
            dres_valid_q <= dres_valid_d;
        end
    end

    // Accept pulses are combinational on the request; held low while reset is asserted.
    always_comb begin
        ires_o       = '0;
        ires_o.valid = ires_valid_q;
        ires_o.ready = grant && !pick_d && !rst_i;
        ires_o.blk   = res_data_q;

        dres_o       = '0;
        dres_o.valid = dres_valid_q;
        dres_o.ready = grant && pick_d && !rst_i;
        dres_o.data  = res_data_q;

        mem_req_o       = '0;
        mem_req_o.valid = (state_q == StSend);
        mem_req_o.addr  = req_addr_q;
        mem_req_o.data  = req_data_q;
        mem_req_o.rw    = req_mask_q;
    end

endmodule

// File: tb/tb_tcore_mem_arbiter.sv
module tb_tcore_mem_arbiter;
    import tcore_mem_arbiter_pkg::*;

    localparam int unsigned D_PRIO_TB = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    ilowX_req_t   ireq;
    ilowX_res_t   ires;
    dlowX_req_t   dreq;
    dlowX_res_t   dres;
    mem_req_t     mreq;
    logic         mem_ready = 1'b0;
    logic         mem_res_valid = 1'b0;
    logic [127:0] mem_res_data = '0;

    tcore_mem_arbiter #(
        .ADDR_W (32),
        .BLK_W  (128),
        .D_PRIO (D_PRIO_TB)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ireq_i          (ireq),
        .ires_o          (ires),
        .dreq_i          (dreq),
        .dres_o          (dres),
        .mem_req_o       (mreq),
        .mem_ready_i     (mem_ready),
        .mem_res_valid_i (mem_res_valid),
        .mem_res_data_i  (mem_res_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requesters: hold valid until their accept pulse is seen.
    bit           i_pend, d_pend;
    logic [31:0]  i_addr, d_addr;
    rw_size_t     d_size;
    bit           d_rw, d_unc;
    logic [127:0] d_data;

    // Memory behaviour knobs (-1 = random).
    int           hold_knob = -1, delay_knob = -1;
    bit           fixed_data_en, inject_res, spurious_en = 1'b1;
    logic [127:0] fixed_data;
    bit           mem_seen, mem_acc;
    int           hold_cnt, wait_cnt;

    // Reference model: transaction-level view of the arbiter.
    bit           m_busy, m_in_send, m_waiting, m_resp_due, m_port, m_last;
    logic [31:0]  m_addr;
    logic [15:0]  m_mask;
    logic [127:0] m_data, m_resp_data;

    // Observation log used by the directed scenarios.
    int           grant_log[$];
    logic [31:0]  last_mem_addr;
    logic [15:0]  last_mem_mask;
    logic [127:0] last_mem_data, last_res_data;
    int           res_count_i, res_count_d, mem_valid_cycles;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_log();
        grant_log.delete();
        res_count_i = 0;
        res_count_d = 0;
        mem_valid_cycles = 0;
    endtask

    // Expected memory request from the granted requester's fields.
    task automatic exp_request(input bit port, output logic [31:0] a, output logic [15:0] m,
                               output logic [127:0] d);
        int len, off;
        m = '0;
        d = '0;
        if (!port) begin
            a = i_addr & 32'hFFFF_FFF0;
        end else begin
            a = d_addr & 32'hFFFF_FFF0;
            if (d_rw && !d_unc) begin
                m = 16'hFFFF;
                d = d_data;
            end else if (d_rw) begin
                len = (d_size == BYTE) ? 1 : (d_size == HALF_WORD) ? 2 : (d_size == WORD) ? 4 : 0;
                off = int'(d_addr[3:0]);
                for (int b = 0; b < 16; b++) m[b] = (b >= off) && (b < off + len);
                for (int l = 0; l < 4; l++) d[l*32 +: 32] = d_data[31:0];
            end
        end
    endtask

    task automatic cycle();
        bit g, w;
        int dly;
        @(negedge clk);
        ireq          = '0;
        ireq.valid    = i_pend;
        ireq.addr     = i_pend ? i_addr : $urandom;
        ireq.uncached = 1'($urandom);
        dreq          = '0;
        dreq.valid    = d_pend;
        dreq.addr     = d_pend ? d_addr : $urandom;
        dreq.rw_size  = d_pend ? d_size : rw_size_t'($urandom_range(3, 0));
        dreq.rw       = d_pend ? d_rw : 1'($urandom);
        dreq.data     = d_pend ? d_data : rand128();
        dreq.uncached = d_pend ? d_unc : 1'($urandom);

        mem_ready     = 1'b0;
        mem_res_valid = 1'b0;
        mem_res_data  = rand128();
        if (inject_res) begin
            mem_res_valid = 1'b1;
        end else if (mem_acc) begin
            if (wait_cnt == 0) begin
                mem_res_valid = 1'b1;
                mem_acc = 1'b0;
                if (fixed_data_en) mem_res_data = fixed_data;
            end else begin
                wait_cnt--;
            end
        end else if (mreq.valid) begin
            if (!mem_seen) begin
                mem_seen = 1'b1;
                hold_cnt = (hold_knob < 0) ? int'($urandom_range(3, 0)) : hold_knob;
            end
            if (hold_cnt == 0) begin
                mem_ready = 1'b1;
                mem_seen  = 1'b0;
                dly = (delay_knob < 0) ? int'($urandom_range(3, 0)) : delay_knob;
                if (dly == 0) begin
                    mem_res_valid = 1'b1;
                    if (fixed_data_en) mem_res_data = fixed_data;
                end else begin
                    mem_acc  = 1'b1;
                    wait_cnt = dly - 1;
                end
            end else begin
                hold_cnt--;
                if (spurious_en && $urandom_range(7, 0) == 0) mem_res_valid = 1'b1;
            end
        end
        #1;

        g = !m_busy && (i_pend || d_pend);
        w = (i_pend && d_pend) ? ((D_PRIO_TB != 0) ? 1'b1 : !m_last) : d_pend;
        check("ires.ready", ires.ready, g && !w);
        check("dres.ready", dres.ready, g && w);
        check("mem.valid", mreq.valid, m_in_send);
        if (m_in_send) begin
            check("mem.addr", mreq.addr, m_addr);
            check("mem.rw", mreq.rw, m_mask);
            check("mem.data", mreq.data, m_data);
        end
        check("ires.valid", ires.valid, m_resp_due && !m_port);
        check("dres.valid", dres.valid, m_resp_due && m_port);
        if (m_resp_due) check("res.data", m_port ? dres.data : ires.blk, m_resp_data);

        if (ires.ready) grant_log.push_back(0);
        if (dres.ready) grant_log.push_back(1);
        if (mreq.valid) begin
            mem_valid_cycles++;
            last_mem_addr = mreq.addr;
            last_mem_mask = mreq.rw;
            last_mem_data = mreq.data;
        end
        if (ires.valid) begin
            res_count_i++;
            last_res_data = ires.blk;
        end
        if (dres.valid) begin
            res_count_d++;
            last_res_data = dres.data;
        end

        m_resp_due = 1'b0;
        if (m_in_send) begin
            if (mem_ready) begin
                m_in_send = 1'b0;
                if (mem_res_valid) begin
                    m_resp_due  = 1'b1;
                    m_resp_data = mem_res_data;
                    m_busy      = 1'b0;
                end else begin
                    m_waiting = 1'b1;
                end
            end
        end else if (m_waiting && mem_res_valid) begin
            m_waiting   = 1'b0;
            m_resp_due  = 1'b1;
            m_resp_data = mem_res_data;
            m_busy      = 1'b0;
        end
        if (g) begin
            m_busy    = 1'b1;
            m_in_send = 1'b1;
            m_port    = w;
            m_last    = w;
            exp_request(w, m_addr, m_mask, m_data);
        end

        if (ires.ready) i_pend = 1'b0;
        if (dres.ready) d_pend = 1'b0;
    endtask

    task automatic reset_dut(input int n);
        @(negedge clk);
        rst = 1'b1;
        ireq.valid = 1'b1;
        dreq.valid = 1'b1;
        mem_ready = 1'b0;
        mem_res_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("rst.mem_req", mreq, '0);
            check("rst.ires", ires, '0);
            check("rst.dres", dres, '0);
        end
        @(negedge clk);
        rst = 1'b0;
        ireq = '0;
        dreq = '0;
        {i_pend, d_pend, mem_seen, mem_acc} = '0;
        {m_busy, m_in_send, m_waiting, m_resp_due, m_last} = '0;
    endtask

    task automatic run_until_idle(input int budget);
        int c = 0;
        while ((i_pend || d_pend || m_busy || m_resp_due) && c < budget) begin
            cycle();
            c++;
        end
        if (c >= budget) check("timeout", 1, 0);
    endtask

    task automatic set_d(input logic [31:0] a, input rw_size_t s, input bit rw, input bit unc,
                         input logic [127:0] dat);
        d_addr = a;
        d_size = s;
        d_rw   = rw;
        d_unc  = unc;
        d_data = dat;
        d_pend = 1'b1;
    endtask

    initial begin
        ireq = '0;
        dreq = '0;
        reset_dut(2);

        // Single icache read.
        clear_log();
        hold_knob = 0; delay_knob = 1; fixed_data_en = 1'b1; fixed_data = {16{8'hA5}};
        i_addr = 32'h8000_0014; i_pend = 1'b1;
        run_until_idle(20);
        check("t1.addr", last_mem_addr, 32'h8000_0010);
        check("t1.rw", last_mem_mask, 16'h0000);
        check("t1.blk", last_res_data, {16{8'hA5}});
        check("t1.count", res_count_i, 1);
        fixed_data_en = 1'b0;

        // Tie from reset under round-robin: D, I, D, I.
        reset_dut(1);
        clear_log();
        for (int r = 0; r < 2; r++) begin
            i_addr = $urandom; i_pend = 1'b1;
            set_d($urandom, WORD, 1'b0, 1'b0, rand128());
            run_until_idle(40);
        end
        check("t2.grants", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            logic [3:0] seq;
            for (int k = 0; k < 4; k++) seq[3-k] = grant_log[k][0];
            check("t2.order", seq, 4'b1010);
        end

        // Uncached byte store.
        clear_log();
        set_d(32'h1000_0006, BYTE, 1'b1, 1'b1, {rand128() >> 32, 32'h0000_00CC});
        run_until_idle(20);
        check("t3.addr", last_mem_addr, 32'h1000_0000);
        check("t3.mask", last_mem_mask, 16'h0040);
        check("t3.data", last_mem_data, {4{32'h0000_00CC}});
        check("t3.ack", res_count_d, 1);

        // Uncached word store, then cached writeback.
        set_d(32'h1000_000C, WORD, 1'b1, 1'b1, rand128());
        run_until_idle(20);
        check("t4.sw_mask", last_mem_mask, 16'hF000);
        begin
            logic [127:0] blk = rand128();
            set_d(32'h2000_0020, BYTE, 1'b1, 1'b0, blk);
            run_until_idle(20);
            check("t4.wb_mask", last_mem_mask, 16'hFFFF);
            check("t4.wb_data", last_mem_data, blk);
            check("t4.wb_addr", last_mem_addr, 32'h2000_0020);
        end

        // Memory stalls acceptance for 5 cycles.
        clear_log();
        hold_knob = 5; delay_knob = 2;
        i_addr = 32'h0000_1238; i_pend = 1'b1;
        run_until_idle(30);
        check("t5.valid_cycles", mem_valid_cycles, 6);
        check("t5.count", res_count_i, 1);

        // Reset while waiting for the response, then a late response.
        hold_knob = 0; delay_knob = 3;
        set_d(32'h0000_4440, NO_SIZE, 1'b0, 1'b0, rand128());
        begin
            int c = 0;
            while (!m_waiting && c < 10) begin
                cycle();
                c++;
            end
            check("t6.reached_wait", m_waiting, 1);
        end
        reset_dut(2);
        clear_log();
        inject_res = 1'b1;
        cycle();
        inject_res = 1'b0;
        repeat (3) cycle();
        check("t6.no_res", res_count_i + res_count_d, 0);
        delay_knob = 1;
        i_addr = 32'h0000_8880; i_pend = 1'b1;
        run_until_idle(20);
        check("t6.after_i", res_count_i, 1);
        check("t6.after_d", res_count_d, 0);

        // Randomized traffic against the model.
        hold_knob = -1; delay_knob = -1;
        reset_dut(1);
        for (int it = 0; it < 1500; it++) begin
            if (!i_pend && $urandom_range(3, 0) == 0) begin
                i_addr = $urandom;
                i_pend = 1'b1;
            end
            if (!d_pend && $urandom_range(3, 0) == 0) begin
                set_d($urandom, rw_size_t'($urandom_range(3, 0)), 1'($urandom), 1'($urandom),
                      rand128());
            end
            if ($urandom_range(299, 0) == 0) reset_dut(1);
            else cycle();
        end
        run_until_idle(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
